// File: rtl/di_bus_arbiter_pkg.sv
// Shared definitions for the two-master DI bus arbiter.
package di_bus_arbiter_pkg;

   localparam int NUM_MASTERS = 2;

   // Endpoint address parked on the bus when nobody owns it; decodes to no terminal.
   localparam logic [15:0] IDLE_EP_DEFAULT = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_BUSY   = 2'd2,
      ST_DRAIN  = 2'd3
   } state_t;

   // One-hot grant vector for a master index.
   function automatic logic [NUM_MASTERS-1:0] onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/di_bus_arbiter_if.sv
// Slave-side DI terminal bus: addresses, strobes, data and ready handshake.
interface di_bus_arbiter_if
   import di_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] diEpAddr;
   logic [ADDR_W-1:0] diRegAddr;
   logic              diRead;
   logic              diWrite;
   logic [DATA_W-1:0] diRegDataIn;
   logic [DATA_W-1:0] diRegDataOut;
   logic              rd_ready;
   logic              wr_ready;

   // The arbiter drives the terminal bus.
   modport master (
      output diEpAddr, diRegAddr, diRead, diWrite, diRegDataIn,
      input  diRegDataOut, rd_ready, wr_ready
   );

   // The terminal answers with read data and readies.
   modport slave (
      input  diEpAddr, diRegAddr, diRead, diWrite, diRegDataIn,
      output diRegDataOut, rd_ready, wr_ready
   );
endinterface

// File: rtl/di_bus_arbiter_rr_grant.sv
// Two-way round-robin pick with a pointer holding the last released master.
module di_rr_grant
   import di_bus_arbiter_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_MASTERS-1:0] req,
   input  logic                   update,
   input  logic                   last_idx,
   output logic                   pick,
   output logic                   any
);
   logic last_q;

   // Record the master that just released; reset to 1 so master 0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_q <= 1'b1;
      else if (update)
         last_q <= last_idx;
   end

   // A lone requester wins outright; on a tie the master not served last wins.
   always_comb begin
      any = |req;
      if (req == 2'b11)
         pick = ~last_q;
      else
         pick = req[1];
   end
endmodule

// File: rtl/di_bus_arbiter.sv
// Shares one DI terminal bus between the HostInterface (master 0) and the
// init sequencer (master 1). Whole transactions are granted; an address
// settle gap precedes the first ready, read data is steered back to the
// issuing master, and a stuck slave is flagged with timeout_err.
module di_bus_arbiter
   import di_bus_arbiter_pkg::*;
#(
   parameter int                ADDR_W  = 16,
   parameter int                DATA_W  = 16,
   parameter int                SETTLE  = 2,
   parameter int                TIMEOUT = 255,
   parameter logic [ADDR_W-1:0] IDLE_EP = ADDR_W'(IDLE_EP_DEFAULT)
)(
   input  logic                          if_clock,
   input  logic                          resetb,
   input  logic [NUM_MASTERS-1:0]        m_req,
   input  logic [NUM_MASTERS*ADDR_W-1:0] m_ep_addr,
   input  logic [NUM_MASTERS*ADDR_W-1:0] m_reg_addr,
   input  logic [NUM_MASTERS-1:0]        m_read,
   input  logic [NUM_MASTERS-1:0]        m_write,
   input  logic [NUM_MASTERS*DATA_W-1:0] m_data_in,
   output logic [NUM_MASTERS-1:0]        m_gnt,
   output logic [NUM_MASTERS-1:0]        m_rd_ready,
   output logic [NUM_MASTERS-1:0]        m_wr_ready,
   output logic [DATA_W-1:0]             m_data_out,
   output logic [NUM_MASTERS-1:0]        m_rvalid,
   di_bus_arbiter_if.master              bus,
   output logic                          timeout_err
);
   localparam logic [2:0] SETTLE_LAST = 3'(SETTLE - 1);
   localparam logic [7:0] TO_MAX      = 8'(TIMEOUT);
   localparam logic [7:0] TO_LAST     = 8'(TIMEOUT - 1);

   state_t            state;
   logic              g_q;
   logic [2:0]        settle_cnt;
   logic [7:0]        to_cnt;
   logic              wanted;
   logic [ADDR_W-1:0] ep_q;
   logic [ADDR_W-1:0] reg_q;

   logic              rvalid_pipe;
   logic              rv_idx;
   logic [DATA_W-1:0] data_hold;

   logic              busy;
   logic              rd_fire;
   logic              wr_fire;
   logic              blocked;
   logic              release_bus;
   logic              rr_pick;
   logic              rr_any;
   logic [ADDR_W-1:0] pick_ep;
   logic [ADDR_W-1:0] pick_reg;
   logic [DATA_W-1:0] sel_data;

   di_rr_grant u_rr (
      .clk      (if_clock),
      .rst_n    (resetb),
      .req      (m_req),
      .update   (release_bus),
      .last_idx (g_q),
      .pick     (rr_pick),
      .any      (rr_any)
   );

   assign busy     = (state == ST_BUSY);
   assign rd_fire  = busy & m_read[g_q] & bus.rd_ready;
   assign wr_fire  = busy & m_write[g_q] & bus.wr_ready;
   assign blocked  = busy & ((m_read[g_q] & ~bus.rd_ready) | (m_write[g_q] & ~bus.wr_ready));
   assign pick_ep  = rr_pick ? m_ep_addr[2*ADDR_W-1:ADDR_W]  : m_ep_addr[ADDR_W-1:0];
   assign pick_reg = rr_pick ? m_reg_addr[2*ADDR_W-1:ADDR_W] : m_reg_addr[ADDR_W-1:0];
   assign sel_data = g_q ? m_data_in[2*DATA_W-1:DATA_W] : m_data_in[DATA_W-1:0];

   assign bus.diEpAddr    = ep_q;
   assign bus.diRegAddr   = reg_q;
   assign bus.diRead      = rd_fire;
   assign bus.diWrite     = wr_fire;
   assign bus.diRegDataIn = busy ? sel_data : '0;

   // Cycles on which the bus returns to IDLE; also advances the round-robin pointer.
   always_comb begin
      release_bus = 1'b0;
      case (state)
         ST_SETTLE: release_bus = ~m_req[g_q];
         ST_BUSY:   release_bus = ~m_req[g_q] & ~rd_fire;
         ST_DRAIN:  release_bus = 1'b1;
         default:   release_bus = 1'b0;
      endcase
   end

   // Readies reach only the granted master, and only once the address has settled.
   always_comb begin
      m_rd_ready = '0;
      m_wr_ready = '0;
      if (busy) begin
         m_rd_ready[g_q] = bus.rd_ready;
         m_wr_ready[g_q] = bus.wr_ready;
      end
   end

   // Grant/settle/busy/drain sequencing, address latch and slave-ready timeout.
   always_ff @(posedge if_clock or negedge resetb) begin
      if (!resetb) begin
         state       <= ST_IDLE;
         m_gnt       <= '0;
         g_q         <= 1'b0;
         settle_cnt  <= '0;
         to_cnt      <= '0;
         wanted      <= 1'b0;
         timeout_err <= 1'b0;
         ep_q        <= IDLE_EP;
         reg_q       <= '0;
      end else begin
         timeout_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rr_any) begin
                  state      <= ST_SETTLE;
                  g_q        <= rr_pick;
                  m_gnt      <= onehot2(rr_pick);
                  ep_q       <= pick_ep;
                  reg_q      <= pick_reg;
                  settle_cnt <= '0;
                  to_cnt     <= '0;
                  wanted     <= 1'b0;
               end
            end
            ST_SETTLE: begin
               settle_cnt <= settle_cnt + 3'd1;
               if (!m_req[g_q]) begin
                  state <= ST_IDLE;
                  m_gnt <= '0;
                  ep_q  <= IDLE_EP;
               end else if (settle_cnt == SETTLE_LAST) begin
                  state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               // Count cycles a strobe waits on a low ready; pulse once, then saturate silently.
               if (rd_fire | wr_fire) begin
                  to_cnt <= '0;
                  wanted <= 1'b0;
               end else if (blocked | wanted) begin
                  wanted <= 1'b1;
                  if (to_cnt != TO_MAX) begin
                     to_cnt <= to_cnt + 8'd1;
                     if (to_cnt == TO_LAST)
                        timeout_err <= 1'b1;
                  end
               end
               if (!m_req[g_q]) begin
                  if (rd_fire) begin
                     // Keep the address one more cycle so the slave can return the data.
                     state <= ST_DRAIN;
                  end else begin
                     state <= ST_IDLE;
                     m_gnt <= '0;
                     ep_q  <= IDLE_EP;
                  end
               end
            end
            ST_DRAIN: begin
               state <= ST_IDLE;
               m_gnt <= '0;
               ep_q  <= IDLE_EP;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Read return: remember who issued the read and capture the slave data a cycle later.
   always_ff @(posedge if_clock or negedge resetb) begin
      if (!resetb) begin
         rvalid_pipe <= 1'b0;
         rv_idx      <= 1'b0;
         data_hold   <= '0;
      end else begin
         rvalid_pipe <= rd_fire;
         if (rd_fire)
            rv_idx <= g_q;
         if (rvalid_pipe)
            data_hold <= bus.diRegDataOut;
      end
   end

   // Steer the returned data valid to the issuing master; data holds between returns.
   always_comb begin
      m_rvalid         = '0;
      m_rvalid[rv_idx] = rvalid_pipe;
      m_data_out       = rvalid_pipe ? bus.diRegDataOut : data_hold;
   end
endmodule

// File: tb/tb_di_bus_arbiter.sv
// Directed bench for di_bus_arbiter: two instances share stimulus, one with
// TIMEOUT=255 (main checks) and one with TIMEOUT=10 (timeout checks).
module tb_di_bus_arbiter;
   import di_bus_arbiter_pkg::*;

   localparam int AW = 16;
   localparam int DW = 16;

   logic          if_clock = 1'b0;
   logic          resetb   = 1'b0;
   logic [1:0]    m_req    = '0;
   logic [1:0]    m_read   = '0;
   logic [1:0]    m_write  = '0;
   logic [2*AW-1:0] m_ep_addr  = '0;
   logic [2*AW-1:0] m_reg_addr = '0;
   logic [2*DW-1:0] m_data_in  = '0;

   logic [1:0]    gnt_a, rrdy_a, wrdy_a, rv_a;
   logic [1:0]    gnt_b, rrdy_b, wrdy_b, rv_b;
   logic [DW-1:0] dout_a, dout_b;
   logic          tmo_a, tmo_b;

   logic          sl_rd_ready = 1'b0;
   logic          sl_wr_ready = 1'b0;
   logic [DW-1:0] sl_rdata    = '0;
   logic [DW-1:0] rd_val      = '0;

   int n_checks  = 0;
   int n_fail    = 0;
   int n_writes  = 0;
   int wr_pushed = 0;
   int n_tmo_a   = 0;
   int n_tmo_b   = 0;

   logic [16:0] rd_q[$];
   logic [15:0] wr_q[$];

   di_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
   di_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

   assign bus_a.rd_ready     = sl_rd_ready;
   assign bus_a.wr_ready     = sl_wr_ready;
   assign bus_a.diRegDataOut = sl_rdata;
   assign bus_b.rd_ready     = sl_rd_ready;
   assign bus_b.wr_ready     = sl_wr_ready;
   assign bus_b.diRegDataOut = sl_rdata;

   di_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SETTLE(2), .TIMEOUT(255)) dut_a (
      .if_clock(if_clock), .resetb(resetb), .m_req(m_req), .m_ep_addr(m_ep_addr),
      .m_reg_addr(m_reg_addr), .m_read(m_read), .m_write(m_write), .m_data_in(m_data_in),
      .m_gnt(gnt_a), .m_rd_ready(rrdy_a), .m_wr_ready(wrdy_a), .m_data_out(dout_a),
      .m_rvalid(rv_a), .bus(bus_a), .timeout_err(tmo_a)
   );

   di_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SETTLE(2), .TIMEOUT(10)) dut_b (
      .if_clock(if_clock), .resetb(resetb), .m_req(m_req), .m_ep_addr(m_ep_addr),
      .m_reg_addr(m_reg_addr), .m_read(m_read), .m_write(m_write), .m_data_in(m_data_in),
      .m_gnt(gnt_b), .m_rd_ready(rrdy_b), .m_wr_ready(wrdy_b), .m_data_out(dout_b),
      .m_rvalid(rv_b), .bus(bus_b), .timeout_err(tmo_b)
   );

   always #5 if_clock = ~if_clock;

   // Slave model: read data appears the cycle after an accepted read.
   always @(posedge if_clock)
      if (bus_a.diRead) sl_rdata <= rd_val;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge if_clock);
      #1;
   endtask

   task automatic do_reset();
      m_req   = '0;
      m_read  = '0;
      m_write = '0;
      resetb  = 1'b0;
      tick();
      tick();
      resetb  = 1'b1;
   endtask

   // Scoreboard side: pop expected read returns and writes as the DUT produces them.
   always @(negedge if_clock) begin
      logic [16:0] e;
      if (rv_a != 2'b00) begin
         if (rd_q.size() == 0) begin
            check("unexpected_rvalid", 32'(rv_a), 32'd0);
         end else begin
            e = rd_q.pop_front();
            check("rvalid_master", 32'(rv_a), e[16] ? 32'd2 : 32'd1);
            check("rdata", 32'(dout_a), 32'(e[15:0]));
         end
      end
      if (bus_a.diWrite) begin
         n_writes++;
         if (wr_q.size() == 0)
            check("unexpected_write", 32'(n_writes), 32'(wr_pushed));
         else
            check("wdata", 32'(bus_a.diRegDataIn), 32'(wr_q.pop_front()));
      end
      if (tmo_a) n_tmo_a++;
      if (tmo_b) n_tmo_b++;
   end

   initial begin
      // Reset values
      tick();
      check("rst_gnt",     32'(gnt_a), 32'd0);
      check("rst_ep",      32'(bus_a.diEpAddr), 32'hFFFF);
      check("rst_reg",     32'(bus_a.diRegAddr), 32'd0);
      check("rst_rd",      32'(bus_a.diRead), 32'd0);
      check("rst_wr",      32'(bus_a.diWrite), 32'd0);
      check("rst_rrdy",    32'(rrdy_a), 32'd0);
      check("rst_rvalid",  32'(rv_a), 32'd0);
      check("rst_dout",    32'(dout_a), 32'd0);
      check("rst_tmo",     32'(tmo_a), 32'd0);
      resetb = 1'b1;

      // Single master 0 read
      sl_rd_ready = 1'b1;
      sl_wr_ready = 1'b1;
      m_ep_addr   = {16'h0040, 16'h0080};
      m_reg_addr  = {16'h0020, 16'h0004};
      m_req       = 2'b01;
      tick();
      check("t1_gnt",    32'(gnt_a), 32'd1);
      check("t1_ep",     32'(bus_a.diEpAddr), 32'h0080);
      check("t1_settle0", 32'(rrdy_a), 32'd0);
      tick();
      check("t1_settle1", 32'(rrdy_a), 32'd0);
      tick();
      check("t1_rrdy",   32'(rrdy_a), 32'd1);
      check("t1_wrdy",   32'(wrdy_a), 32'd1);
      m_read = 2'b01;
      rd_val = 16'h1234;
      rd_q.push_back({1'b0, 16'h1234});
      #1;
      check("t1_diread", 32'(bus_a.diRead), 32'd1);
      check("t1_regaddr", 32'(bus_a.diRegAddr), 32'h0004);
      tick();
      check("t1_rvalid", 32'(rv_a), 32'd1);
      check("t1_dout",   32'(dout_a), 32'h1234);
      m_read = 2'b00;
      m_req  = 2'b00;
      tick();
      check("t1_rel_gnt", 32'(gnt_a), 32'd0);
      check("t1_rel_ep",  32'(bus_a.diEpAddr), 32'hFFFF);

      // Tie from reset, master 1 strobes ignored while master 0 holds the bus
      do_reset();
      m_req     = 2'b11;
      m_read    = 2'b10;
      m_write   = 2'b10;
      m_data_in = {16'hDEAD, 16'h0000};
      tick();
      check("t2_gnt0", 32'(gnt_a), 32'd1);
      tick();
      tick();
      check("t2_no_rd", 32'(bus_a.diRead), 32'd0);
      check("t2_no_wr", 32'(bus_a.diWrite), 32'd0);
      check("t2_rrdy0", 32'(rrdy_a), 32'd1);
      m_req   = 2'b10;
      m_read  = 2'b00;
      m_write = 2'b00;
      tick();
      check("t2_idle_gnt", 32'(gnt_a), 32'd0);
      check("t2_idle_ep",  32'(bus_a.diEpAddr), 32'hFFFF);
      tick();
      check("t2_gnt1", 32'(gnt_a), 32'd2);
      check("t2_ep1",  32'(bus_a.diEpAddr), 32'h0040);
      check("t2_reg1", 32'(bus_a.diRegAddr), 32'h0020);
      tick();
      tick();
      check("t2_rrdy1", 32'(rrdy_a), 32'd2);
      m_req = 2'b00;
      tick();
      check("t2_rel", 32'(gnt_a), 32'd0);

      // Slow slave: write held off 40 cycles
      n_tmo_a     = 0;
      n_tmo_b     = 0;
      sl_wr_ready = 1'b0;
      m_req       = 2'b10;
      m_write     = 2'b10;
      m_data_in   = {16'hBEEF, 16'h0000};
      wr_q.push_back(16'hBEEF);
      wr_pushed++;
      tick();
      tick();
      tick();
      check("t3_wrdy_low", 32'(wrdy_a), 32'd0);
      repeat (40) tick();
      check("t3_no_write", 32'(n_writes), 32'd0);
      sl_wr_ready = 1'b1;
      #1;
      check("t3_diwrite", 32'(bus_a.diWrite), 32'd1);
      check("t3_wdata",   32'(bus_a.diRegDataIn), 32'hBEEF);
      check("t3_wrdy1",   32'(wrdy_a), 32'd2);
      tick();
      m_write = 2'b00;
      m_req   = 2'b00;
      tick();
      check("t3_one_write", 32'(n_writes), 32'd1);
      check("t3_no_tmo_a",  32'(n_tmo_a), 32'd0);
      check("t3_tmo_b_once", 32'(n_tmo_b), 32'd1);

      // Timeout: rd_ready stuck low, TIMEOUT=10 instance
      n_tmo_a     = 0;
      n_tmo_b     = 0;
      sl_rd_ready = 1'b0;
      m_req       = 2'b01;
      tick();
      tick();
      tick();
      m_read = 2'b01;
      for (int i = 1; i <= 14; i++) begin
         tick();
         check($sformatf("t4_tmo_c%0d", i), 32'(tmo_b), 32'(i == 10));
      end
      check("t4_gnt_kept", 32'(gnt_b), 32'd1);
      check("t4_tmo_once", 32'(n_tmo_b), 32'd1);
      check("t4_no_tmo_a", 32'(n_tmo_a), 32'd0);
      m_read      = 2'b00;
      m_req       = 2'b00;
      sl_rd_ready = 1'b1;
      tick();

      // Release with a read in flight: DRAIN holds the address one cycle
      m_req = 2'b01;
      tick();
      tick();
      tick();
      m_read = 2'b01;
      m_req  = 2'b00;
      rd_val = 16'h5A5A;
      rd_q.push_back({1'b0, 16'h5A5A});
      #1;
      check("t5_diread", 32'(bus_a.diRead), 32'd1);
      tick();
      check("t5_drain_rd",  32'(bus_a.diRead), 32'd0);
      check("t5_drain_ep",  32'(bus_a.diEpAddr), 32'h0080);
      check("t5_drain_gnt", 32'(gnt_a), 32'd1);
      check("t5_rvalid",    32'(rv_a), 32'd1);
      check("t5_dout",      32'(dout_a), 32'h5A5A);
      m_read = 2'b00;
      tick();
      check("t5_idle_ep",  32'(bus_a.diEpAddr), 32'hFFFF);
      check("t5_idle_gnt", 32'(gnt_a), 32'd0);
      check("t5_hold",     32'(dout_a), 32'h5A5A);

      // Async reset mid-burst: strobes and grant drop without a clock edge
      m_req = 2'b10;
      tick();
      tick();
      tick();
      check("t6_gnt1", 32'(gnt_a), 32'd2);
      m_read = 2'b10;
      rd_val = 16'h7777;
      #1;
      check("t6_diread", 32'(bus_a.diRead), 32'd1);
      #1;
      resetb = 1'b0;
      #1;
      check("t6_rd_drop",  32'(bus_a.diRead), 32'd0);
      check("t6_gnt_drop", 32'(gnt_a), 32'd0);
      check("t6_ep",       32'(bus_a.diEpAddr), 32'hFFFF);
      check("t6_reg",      32'(bus_a.diRegAddr), 32'd0);
      check("t6_rrdy",     32'(rrdy_a), 32'd0);
      check("t6_dout",     32'(dout_a), 32'd0);
      m_read = 2'b00;
      m_req  = 2'b00;
      tick();
      tick();
      resetb = 1'b1;
      tick();
      tick();
      check("t6_rvalid", 32'(rv_a), 32'd0);

      check("end_rd_q", 32'(rd_q.size()), 32'd0);
      check("end_wr_q", 32'(wr_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
